// File: rtl/regfile_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package regfile_arb_pkg;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int STAT_W = 16;

  // Low bit of slice idx in a packed per-requester bus of element width w.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/regfile_wport_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester at or after rr_ptr.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [PW-1:0]   rr_ptr,
  output logic [PW-1:0]   winner,
  output logic            any_valid
);
  always_comb begin
    winner    = '0;
    any_valid = |req_valid;
    // Scan from farthest to nearest so the closest valid to rr_ptr wins last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid[idx]) winner = PW'(idx);
    end
  end
endmodule

// File: rtl/regfile_wport_arbiter.sv
// Round-robin arbiter sharing the regfile write port among NREQ writeback sources.
// Define REGFILE_ARB_STATS_EN to add saturating grant/drop/stall counters.
module regfile_wport_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = regfile_arb_pkg::AW,
  parameter int DW   = regfile_arb_pkg::DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               stall,
  input  logic               flush,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               pend_valid,
  output logic [AW-1:0]      pend_addr
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [NREQ*STAT_W-1:0] stat_grant,
  output logic [STAT_W-1:0]      stat_drop,
  output logic [STAT_W-1:0]      stat_stall
`endif
);
  localparam int PW = $clog2(NREQ);

  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] winner;
  logic          any_valid, can_acc, xfer, win_zero;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  // Gating with rst keeps grants silent while the block is held in reset.
  assign can_acc  = rst && !stall && !flush;
  assign xfer     = any_valid && can_acc;
  assign win_addr = req_addr[slice_lo(int'(winner), AW) +: AW];
  assign win_data = req_data[slice_lo(int'(winner), DW) +: DW];
  assign win_zero = (win_addr == AW'(REG_ZERO));

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[winner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (xfer) begin
        rr_ptr <= (winner == PW'(NREQ - 1)) ? '0 : winner + 1'b1;
        if (!win_zero) begin
          out_addr <= win_addr;
          out_data <= win_data;
        end
      end
      // Writes to $0 consume the grant but never reach the regfile.
      out_valid <= xfer && !win_zero;
    end
  end

  assign rf_we      = out_valid && !stall && !flush;
  assign rf_waddr   = out_addr;
  assign rf_wdata   = out_data;
  assign pend_valid = out_valid;
  assign pend_addr  = out_addr;

`ifdef REGFILE_ARB_STATS_EN
  logic [NREQ-1:0][STAT_W-1:0] grant_cnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_grant
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) grant_cnt[i] <= '0;
      else if (xfer && winner == PW'(i) && grant_cnt[i] != '1)
        grant_cnt[i] <= grant_cnt[i] + 1'b1;
    end
  end
  assign stat_grant = grant_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_drop  <= '0;
      stat_stall <= '0;
    end else begin
      if (xfer && win_zero && stat_drop != '1) stat_drop <= stat_drop + 1'b1;
      if (stall && out_valid && stat_stall != '1) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed self-checking bench for regfile_wport_arbiter (NREQ=3).
module tb_regfile_wport_arbiter;
  localparam int NREQ = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic               clk, rst, stall, flush;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               rf_we, pend_valid;
  logic [AW-1:0]      rf_waddr, pend_addr;
  logic [DW-1:0]      rf_wdata;
`ifdef REGFILE_ARB_STATS_EN
  logic [NREQ*16-1:0] stat_grant;
  logic [15:0]        stat_drop, stat_stall;
`endif

  int n_cmp, n_err;

  regfile_wport_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .stall(stall), .flush(flush),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_valid(pend_valid), .pend_addr(pend_addr)
`ifdef REGFILE_ARB_STATS_EN
    , .stat_grant(stat_grant), .stat_drop(stat_drop), .stat_stall(stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = '0; stall = 1'b0; flush = 1'b0;
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    tick(); tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd0) begin n_err++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'd0) begin n_err++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
    n_cmp++; if (pend_valid !== 1'b0) begin n_err++; $display("FAIL reset_pend: got %b want 0", pend_valid); end
    req_valid = 3'b001;
    #1;
    n_cmp++; if (req_ready !== 3'b000) begin n_err++; $display("FAIL reset_ready: got %b want 000", req_ready); end
    req_valid = '0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_ready: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rf_we !== 1'b1) begin n_err++; $display("FAIL single_we: got %b want 1", rf_we); end
    n_cmp++; if (rf_waddr !== 5'd5) begin n_err++; $display("FAIL single_waddr: got %0d want 5", rf_waddr); end
    n_cmp++; if (rf_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_wdata: got %h want deadbeef", rf_wdata); end
    n_cmp++; if (pend_valid !== 1'b1 || pend_addr !== 5'd5) begin n_err++; $display("FAIL single_pend: got %b/%0d want 1/5", pend_valid, pend_addr); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL single_we_off: got %b want 0", rf_we); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 5'(i + 1), 32'hA0 + i);
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_rdy = 3'b001 << (c % 3);
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", c, req_ready, exp_rdy); end
      tick();
      n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'(c % 3 + 1) || rf_wdata !== 32'hA0 + (c % 3))
        begin n_err++; $display("FAIL rr_write[%0d]: got we=%b a=%0d d=%h want we=1 a=%0d", c, rf_we, rf_waddr, rf_wdata, c % 3 + 1); end
    end
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rr_wrap: got %b want 001", req_ready); end
    req_valid = '0;
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL rr_drain: got %b want 0", rf_we); end
  endtask

  task automatic test_stall();
    set_req(0, 5'd7, 32'h7777);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL stall_pre_ready: got %b want 001", req_ready); end
    tick();
    req_valid = '0;
    set_req(1, 5'd8, 32'h8888);
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_cmp++; if (rf_we !== 1'b0 || req_ready !== 3'b000) begin n_err++; $display("FAIL stall_hold[%0d]: got we=%b rdy=%b want 0/000", c, rf_we, req_ready); end
      n_cmp++; if (pend_valid !== 1'b1 || pend_addr !== 5'd7) begin n_err++; $display("FAIL stall_pend[%0d]: got %b/%0d want 1/7", c, pend_valid, pend_addr); end
      tick();
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h7777) begin n_err++; $display("FAIL stall_release: got we=%b a=%0d d=%h want 1/7/7777", rf_we, rf_waddr, rf_wdata); end
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL stall_rel_ready: got %b want 010", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'h8888) begin n_err++; $display("FAIL stall_next: got we=%b a=%0d d=%h want 1/8/8888", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL stall_drain: got %b want 0", rf_we); end
`ifdef REGFILE_ARB_STATS_EN
    n_cmp++; if (stat_stall !== 16'd2) begin n_err++; $display("FAIL stat_stall: got %0d want 2", stat_stall); end
`endif
  endtask

  task automatic test_drop();
    do_reset();
    set_req(2, 5'd0, 32'h1234);
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL drop_ready: got %b want 100", req_ready); end
    tick();
    req_valid = '0;
    n_cmp++; if (rf_we !== 1'b0 || pend_valid !== 1'b0) begin n_err++; $display("FAIL drop_we: got we=%b pend=%b want 0/0", rf_we, pend_valid); end
`ifdef REGFILE_ARB_STATS_EN
    n_cmp++; if (stat_drop !== 16'd1) begin n_err++; $display("FAIL stat_drop: got %0d want 1", stat_drop); end
    n_cmp++; if (stat_grant !== {16'd1, 16'd0, 16'd0}) begin n_err++; $display("FAIL stat_grant: got %h want 000100000000", stat_grant); end
`endif
    set_req(1, 5'd3, 32'h3);
    set_req(2, 5'd4, 32'h4);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL drop_ptr: got %b want 010", req_ready); end
    req_valid = '0;
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL drop_idle: got %b want 0", rf_we); end
  endtask

  task automatic test_flush();
    set_req(0, 5'd9, 32'h9999);
    tick();
    req_valid = '0;
    set_req(1, 5'd10, 32'hAAAA);
    flush = 1'b1;
    stall = 1'b1;
    #1;
    n_cmp++; if (rf_we !== 1'b0 || req_ready !== 3'b000) begin n_err++; $display("FAIL flush_hold: got we=%b rdy=%b want 0/000", rf_we, req_ready); end
    n_cmp++; if (pend_valid !== 1'b1 || pend_addr !== 5'd9) begin n_err++; $display("FAIL flush_pre_pend: got %b/%0d want 1/9", pend_valid, pend_addr); end
    tick();
    flush = 1'b0;
    stall = 1'b0;
    req_valid = '0;
    n_cmp++; if (pend_valid !== 1'b0 || rf_we !== 1'b0) begin n_err++; $display("FAIL flush_clear: got pend=%b we=%b want 0/0", pend_valid, rf_we); end
    tick();
    n_cmp++; if (rf_we !== 1'b0) begin n_err++; $display("FAIL flush_never: got %b want 0", rf_we); end
    req_valid = 3'b011;
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_err++; $display("FAIL flush_ptr: got %b want 010", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 5'd3, 32'h33);
    set_req(1, 5'd4, 32'h44);
    tick();
    tick();
    req_valid = '0;
    #1;
    n_cmp++; if (pend_valid !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd4) begin n_err++; $display("FAIL rstmid_pre: got pend=%b we=%b a=%0d want 1/1/4", pend_valid, rf_we, rf_waddr); end
    rst = 1'b0;
    #1;
    n_cmp++; if (rf_we !== 1'b0 || pend_valid !== 1'b0 || rf_waddr !== 5'd0) begin n_err++; $display("FAIL rstmid_clear: got we=%b pend=%b a=%0d want 0/0/0", rf_we, pend_valid, rf_waddr); end
    tick();
    rst = 1'b1;
    set_req(0, 5'd11, 32'hB0);
    set_req(2, 5'd12, 32'hB2);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL rstmid_first: got %b want 001", req_ready); end
    tick();
    n_cmp++; if (rf_we !== 1'b1 || rf_waddr !== 5'd11) begin n_err++; $display("FAIL rstmid_write: got we=%b a=%0d want 1/11", rf_we, rf_waddr); end
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_err++; $display("FAIL rstmid_second: got %b want 100", req_ready); end
    req_valid = '0;
    tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    req_valid = '0; req_addr = '0; req_data = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_stall();
    test_drop();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
